// File: rtl/line_clear_if.sv
// Port-A grid bus plus the start/done handshake between the game
// controller and the line-clear engine.
interface line_clear_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [4:0]            lines_cleared;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Controller and grid memory side
  modport master (
    output start, mem_rdata,
    input  busy, done, lines_cleared, mem_addr, mem_wdata, mem_we
  );

  // Line-clear engine side
  modport slave (
    input  start, mem_rdata,
    output busy, done, lines_cleared, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/line_clear.sv
// line_clear: after a piece locks, scans the playfield from the bottom row
// upward, removes every full row by dropping all rows above it by one,
// blanks the top row, and reports how many lines were removed.
module line_clear #(
  parameter int COLS       = 10,
  parameter int ROWS       = 20,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  line_clear_if.slave bus
);
  localparam int            CW       = $clog2(COLS + 1);
  localparam logic [4:0]    LAST_ROW = 5'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] NUM_COLS = CW'(COLS);
  localparam logic [CW-1:0] ONE_COL  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DECIDE,
    S_SHIFT,
    S_CLEAR_TOP,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            row_q, row_d;
  logic [4:0]            dst_q, dst_d;
  logic [4:0]            lines_q, lines_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;
  logic [1:0]            phase_q, phase_d;
  logic                  full_q, full_d;
  logic                  rd_v1_q, rd_v1_d;
  logic                  rd_v2_q, rd_v2_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [4:0] r,
                                                      input logic [CW-1:0] c);
    return ADDR_WIDTH'(r) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(c);
  endfunction

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lines_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_we        = we_q;

  // Next-state and registered-output computation for the scan/shift sequencer
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dst_d   = dst_q;
    lines_d = lines_q;
    col_d   = col_q;
    rcnt_d  = rcnt_q;
    phase_d = phase_q;
    full_d  = full_q;
    rd_v1_d = 1'b0;
    rd_v2_d = rd_v1_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lines_d = 5'd0;
          row_d   = LAST_ROW;
          col_d   = '0;
          rcnt_d  = '0;
          full_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (col_q < NUM_COLS) begin
          addr_d  = cell_addr(row_q, col_q);
          rd_v1_d = 1'b1;
          col_d   = col_q + ONE_COL;
        end
        if (rd_v2_q) begin
          full_d = full_q & (bus.mem_rdata != '0);
          rcnt_d = rcnt_q + ONE_COL;
          if (rcnt_q == LAST_COL) begin
            state_d = S_DECIDE;
          end
        end
      end

      S_DECIDE: begin
        col_d   = '0;
        rcnt_d  = '0;
        full_d  = 1'b1;
        phase_d = 2'd0;
        if (full_q) begin
          if (lines_q != 5'd31) begin
            lines_d = lines_q + 5'd1;
          end
          dst_d   = row_q;
          state_d = (row_q == 5'd0) ? S_CLEAR_TOP : S_SHIFT;
        end else if (row_q == 5'd0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d   = row_q - 5'd1;
          state_d = S_CHECK;
        end
      end

      S_SHIFT: begin
        case (phase_q)
          2'd0: begin
            addr_d  = cell_addr(dst_q - 5'd1, col_q);
            phase_d = 2'd1;
          end
          2'd1: begin
            phase_d = 2'd2;
          end
          default: begin
            addr_d  = cell_addr(dst_q, col_q);
            wdata_d = bus.mem_rdata;
            we_d    = 1'b1;
            phase_d = 2'd0;
            if (col_q == LAST_COL) begin
              col_d = '0;
              if (dst_q == 5'd1) begin
                state_d = S_CLEAR_TOP;
              end else begin
                dst_d = dst_q - 5'd1;
              end
            end else begin
              col_d = col_q + ONE_COL;
            end
          end
        endcase
      end

      S_CLEAR_TOP: begin
        addr_d  = cell_addr(5'd0, col_q);
        wdata_d = '0;
        we_d    = 1'b1;
        if (col_q == LAST_COL) begin
          col_d   = '0;
          rcnt_d  = '0;
          full_d  = 1'b1;
          state_d = S_CHECK;
        end else begin
          col_d = col_q + ONE_COL;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, dropping mem_we at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= 5'd0;
      dst_q   <= 5'd0;
      lines_q <= 5'd0;
      col_q   <= '0;
      rcnt_q  <= '0;
      phase_q <= 2'd0;
      full_q  <= 1'b0;
      rd_v1_q <= 1'b0;
      rd_v2_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dst_q   <= dst_d;
      lines_q <= lines_d;
      col_q   <= col_d;
      rcnt_q  <= rcnt_d;
      phase_q <= phase_d;
      full_q  <= full_d;
      rd_v1_q <= rd_v1_d;
      rd_v2_q <= rd_v2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule
